// File: rtl/led_seq_pkg.sv
// ----------------------------------------------------------------------------
// led_seq_pkg
//   Shared types and helpers for the LED pattern sequencer.
//   - led_mode_t    : display mode encoding (COUNT, SHIFT, BOUNCE, BLINK)
//   - next_mode()   : mode that follows a given mode in the display rotation
//   - entry_pattern(): LED pattern loaded when a mode is entered, for a
//                      given LED count (up to LED_MAX_WIDTH LEDs)
// ----------------------------------------------------------------------------
package led_seq_pkg;

    localparam int unsigned LED_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        COUNT  = 2'd0,
        SHIFT  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } led_mode_t;

    function automatic led_mode_t next_mode(input led_mode_t mode);
        case (mode)
            COUNT:   return SHIFT;
            SHIFT:   return BOUNCE;
            BOUNCE:  return BLINK;
            default: return COUNT;
        endcase
    endfunction

    // Result is LED_MAX_WIDTH wide; callers keep the low 'width' bits.
    function automatic logic [LED_MAX_WIDTH-1:0] entry_pattern(
        input led_mode_t   mode,
        input int unsigned width
    );
        logic [LED_MAX_WIDTH-1:0] pattern;
        case (mode)
            COUNT:   pattern = '0;
            SHIFT:   pattern = LED_MAX_WIDTH'(1);
            BOUNCE:  pattern = LED_MAX_WIDTH'(1);
            default: pattern = {LED_MAX_WIDTH{1'b1}} >> (LED_MAX_WIDTH - width);
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ----------------------------------------------------------------------------
// led_tick_gen
//   Slow enable strobe generator: free-running prescaler plus single-step
//   edge detect, with a registered one-cycle tick output.
//
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_run       1 = free-run from the prescaler, 0 = prescaler held at 0
//   i_step      rising edge requests one tick while i_run = 0
//   i_restart   synchronous clear of prescaler, step history and tick
//   i_prescale  tick period minus 1
//   o_tick      registered one-cycle strobe
// ----------------------------------------------------------------------------
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 24
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_run,
    input  logic                      i_step,
    input  logic                      i_restart,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_tick
);

    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic                      step_q;
    logic                      step_prev_q;
    logic                      tick_q;
    logic                      step_edge;

    // Edge is taken between two registered samples, so a step reaches
    // o_tick two cycles after it arrives at the input.
    assign step_edge = step_q & ~step_prev_q & ~i_run;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q     <= '0;
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
            tick_q      <= 1'b0;
        end else if (i_restart) begin
            presc_q     <= '0;
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            step_q      <= i_step;
            step_prev_q <= step_q;
            if (i_run) begin
                // >= rather than == so a lowered period takes effect at once.
                if (presc_q >= i_prescale) begin
                    presc_q <= '0;
                    tick_q  <= 1'b1;
                end else begin
                    presc_q <= presc_q + 1'b1;
                    tick_q  <= 1'b0;
                end
            end else begin
                presc_q <= '0;
                tick_q  <= step_edge;
            end
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// led_pattern_sequencer
//   Paces the LED datapath with a slow tick and walks the LEDs through four
//   display modes (COUNT, SHIFT, BOUNCE, BLINK), DWELL ticks each.
//
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_run       1 = free-run on prescaler ticks
//   i_step      rising edge requests one tick while i_run = 0
//   i_restart   synchronous return to the reset state
//   i_prescale  tick period minus 1
//   o_tick      registered one-cycle enable strobe
//   o_led       registered LED pattern
//   o_mode      current display mode
//   o_wrap      one-cycle pulse after BLINK hands over to COUNT
// ----------------------------------------------------------------------------
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 24,
    parameter int unsigned LED_WIDTH      = 8,
    parameter int unsigned DWELL          = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_run,
    input  logic                      i_step,
    input  logic                      i_restart,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_tick,
    output logic [LED_WIDTH-1:0]      o_led,
    output logic [1:0]                o_mode,
    output logic                      o_wrap
);

    localparam int unsigned          S_WIDTH = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [S_WIDTH-1:0]   S_LAST  = S_WIDTH'(DWELL - 1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic                 tick;
    led_mode_t            mode_q, mode_d;
    logic [S_WIDTH-1:0]   s_q, s_d;
    dir_t                 dir_q, dir_d, dir_upd;
    logic [LED_WIDTH-1:0] led_q, led_d, led_upd, led_entry;
    logic                 wrap_q, wrap_d;

    led_tick_gen #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_tick_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_run      (i_run),
        .i_step     (i_step),
        .i_restart  (i_restart),
        .i_prescale (i_prescale),
        .o_tick     (tick)
    );

    assign led_entry = LED_WIDTH'(entry_pattern(next_mode(mode_q), LED_WIDTH));

    // In-mode LED update for one tick.
    always_comb begin
        led_upd = led_q;
        dir_upd = dir_q;
        case (mode_q)
            COUNT:  led_upd = led_q + 1'b1;
            SHIFT:  led_upd = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
            BOUNCE: begin
                // Turn around at either end so the lit LED never leaves the bar.
                if (dir_q == DIR_UP) begin
                    if (led_q[LED_WIDTH-1]) begin
                        dir_upd = DIR_DOWN;
                        led_upd = led_q >> 1;
                    end else begin
                        led_upd = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        dir_upd = DIR_UP;
                        led_upd = led_q << 1;
                    end else begin
                        led_upd = led_q >> 1;
                    end
                end
            end
            BLINK:  led_upd = ~led_q;
            default: ;
        endcase
    end

    // Next-state logic; restart wins over a coincident tick.
    always_comb begin
        mode_d = mode_q;
        s_d    = s_q;
        dir_d  = dir_q;
        led_d  = led_q;
        wrap_d = 1'b0;
        if (i_restart) begin
            mode_d = COUNT;
            s_d    = '0;
            dir_d  = DIR_UP;
            led_d  = '0;
        end else if (tick) begin
            if (s_q == S_LAST) begin
                s_d    = '0;
                mode_d = next_mode(mode_q);
                dir_d  = DIR_UP;
                led_d  = led_entry;
                wrap_d = (mode_q == BLINK);
            end else begin
                s_d   = s_q + 1'b1;
                dir_d = dir_upd;
                led_d = led_upd;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q <= COUNT;
            s_q    <= '0;
            dir_q  <= DIR_UP;
            led_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            s_q    <= s_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        o_tick = tick;
        o_led  = led_q;
        o_mode = mode_q;
        o_wrap = wrap_q;
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

    localparam int unsigned PW = 24;
    localparam int unsigned LW = 8;
    localparam int unsigned DW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_run = 1'b0;
    logic          i_step = 1'b0;
    logic          i_restart = 1'b0;
    logic [PW-1:0] i_prescale = '0;
    logic          o_tick;
    logic [LW-1:0] o_led;
    logic [1:0]    o_mode;
    logic          o_wrap;

    always #5 i_clk = ~i_clk;

    led_pattern_sequencer #(
        .PRESCALE_WIDTH (PW),
        .LED_WIDTH      (LW),
        .DWELL          (DW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_run      (i_run),
        .i_step     (i_step),
        .i_restart  (i_restart),
        .i_prescale (i_prescale),
        .o_tick     (o_tick),
        .o_led      (o_led),
        .o_mode     (o_mode),
        .o_wrap     (o_wrap)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned ticks_seen = 0;
    int unsigned wraps_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: LED pattern and mode after n ticks since reset.
    function automatic void model(input int unsigned n, output logic [LW-1:0] led,
                                  output logic [1:0] mode);
        int unsigned k, ph, p, pos;
        k    = n % DW;
        ph   = (n / DW) % 4;
        mode = 2'(ph);
        case (ph)
            0: led = LW'(k);
            1: led = LW'(1) << (k % LW);
            2: begin
                p   = k % (2 * LW - 2);
                pos = (p < LW) ? p : (2 * LW - 2 - p);
                led = LW'(1) << pos;
            end
            default: led = (k % 2 == 0) ? {LW{1'b1}} : {LW{1'b0}};
        endcase
    endfunction

    typedef struct {
        logic [LW-1:0] led;
        logic [1:0]    mode;
        logic          wrap;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int unsigned m_n = 0;

    // Scoreboard: each cycle push what the next cycle must show, pop and compare.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst_n) begin
            sb.delete();
            m_n = 0;
            chk("rst_led",  32'(o_led),  32'd0);
            chk("rst_mode", 32'(o_mode), 32'd0);
            chk("rst_wrap", 32'(o_wrap), 32'd0);
            chk("rst_tick", 32'(o_tick), 32'd0);
            cur = '{led: '0, mode: 2'd0, wrap: 1'b0};
            sb.push_back(cur);
        end else begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_led",  32'(o_led),  32'(e.led));
                chk("sb_mode", 32'(o_mode), 32'(e.mode));
                chk("sb_wrap", 32'(o_wrap), 32'(e.wrap));
                if (o_mode == 2'd2)
                    chk("bounce_onehot", 32'($countones(o_led)), 32'd1);
            end
            if (o_tick) ticks_seen++;
            if (o_wrap) wraps_seen++;
            if (i_restart) begin
                m_n = 0;
                cur = '{led: '0, mode: 2'd0, wrap: 1'b0};
            end else if (o_tick) begin
                m_n++;
                model(m_n, cur.led, cur.mode);
                cur.wrap = (m_n % (4 * DW) == 0);
            end else begin
                cur.wrap = 1'b0;
            end
            sb.push_back(cur);
        end
    end

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_restart();
        next_cycle();
        i_restart = 1'b1;
        i_run     = 1'b0;
        i_step    = 1'b0;
        next_cycle();
        i_restart = 1'b0;
    endtask

    // n = 1-based index of the negedge at which o_tick is seen.
    task automatic wait_tick(input int unsigned limit, output int unsigned n);
        n = 32'hFFFF;
        for (int unsigned i = 1; i <= limit; i++) begin
            @(negedge i_clk);
            if (o_tick) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic step_pulse(input int unsigned len);
        i_step = 1'b1;
        for (int unsigned c = 0; c < len + 4; c++) begin
            @(negedge i_clk);
            chk("step_tick", 32'(o_tick), 32'(c == 2));
            next_cycle();
            i_step = (c + 1 < len);
        end
    endtask

    typedef struct {
        logic [PW-1:0] prescale;
        int unsigned   lat;
        int unsigned   period;
    } vec_t;

    initial begin
        vec_t        vecs[4];
        int unsigned n, cnt, w0, t0;
        logic        found;

        vecs[0] = '{prescale: 24'd0, lat: 1,  period: 1};
        vecs[1] = '{prescale: 24'd1, lat: 2,  period: 2};
        vecs[2] = '{prescale: 24'd3, lat: 4,  period: 4};
        vecs[3] = '{prescale: 24'd9, lat: 10, period: 10};

        // Reset with run already high, prescale 3.
        #1 i_rst_n = 1'b0;
        i_run      = 1'b1;
        i_prescale = 24'd3;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        wait_tick(50, n);
        chk("reset_first_tick", n - 1, 32'd4);
        wait_tick(50, n);
        chk("reset_period", n, 32'd4);
        @(negedge i_clk);
        chk("count_led_after_2", 32'(o_led), 32'd2);

        // Tick latency / period table.
        for (int unsigned v = 0; v < 4; v++) begin
            do_restart();
            i_prescale = vecs[v].prescale;
            i_run      = 1'b1;
            wait_tick(100, n);
            chk("vec_first_tick", n - 1, vecs[v].lat);
            wait_tick(100, n);
            chk("vec_period", n, vecs[v].period);
        end

        // Full rotation through all four modes.
        do_restart();
        i_prescale = 24'd0;
        i_run      = 1'b1;
        w0         = wraps_seen;
        cnt        = 0;
        for (int unsigned i = 0; i < 400 && cnt < 4 * DW; i++) begin
            @(negedge i_clk);
            if (o_tick) cnt++;
        end
        chk("full_cycle_ticks", cnt, 4 * DW);
        @(negedge i_clk);
        chk("wrap_pulse", 32'(o_wrap), 32'd1);
        chk("wrap_mode",  32'(o_mode), 32'd0);
        chk("wrap_led",   32'(o_led),  32'd0);
        @(negedge i_clk);
        chk("wrap_count", wraps_seen - w0, 32'd1);

        // Single-step: two short pulses and one held for 5 cycles.
        do_restart();
        t0 = ticks_seen;
        step_pulse(1);
        step_pulse(1);
        step_pulse(5);
        @(negedge i_clk);
        chk("step_count", ticks_seen - t0, 32'd3);

        // Steps while running are ignored.
        do_restart();
        i_prescale = 24'd200;
        i_run      = 1'b1;
        t0         = ticks_seen;
        for (int unsigned i = 0; i < 30; i++) begin
            i_step = i[1];
            next_cycle();
        end
        i_step = 1'b0;
        @(negedge i_clk);
        chk("run_step_ignored", ticks_seen - t0, 32'd0);

        // Restart colliding with a tick in SHIFT mid-dwell.
        do_restart();
        i_prescale = 24'd0;
        i_run      = 1'b1;
        found      = 1'b0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_mode == 2'd1 && o_led == 8'h08) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_shift", 32'(found), 32'd1);
        next_cycle();
        i_restart = 1'b1;
        @(negedge i_clk);
        chk("restart_cycle_tick", 32'(o_tick), 32'd1);
        next_cycle();
        i_restart = 1'b0;
        @(negedge i_clk);
        chk("restart_mode", 32'(o_mode), 32'd0);
        chk("restart_led",  32'(o_led),  32'd0);
        chk("restart_tick", 32'(o_tick), 32'd0);
        cnt = 0;
        for (int unsigned i = 0; i < 100; i++) begin
            if (o_mode == 2'd1) break;
            if (o_tick) cnt++;
            @(negedge i_clk);
        end
        chk("restart_dwell", cnt, DW);

        // Asynchronous reset in the middle of a cycle.
        @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1;
        chk("async_rst_led",  32'(o_led),  32'd0);
        chk("async_rst_mode", 32'(o_mode), 32'd0);
        chk("async_rst_tick", 32'(o_tick), 32'd0);
        next_cycle();
        i_rst_n = 1'b1;

        // Lowering the period while the prescaler is past the new limit.
        do_restart();
        i_prescale = 24'd100;
        i_run      = 1'b1;
        repeat (50) @(posedge i_clk);
        #1 i_prescale = 24'd5;
        @(negedge i_clk);
        chk("presc_no_early", 32'(o_tick), 32'd0);
        @(negedge i_clk);
        chk("presc_drop_tick", 32'(o_tick), 32'd1);
        wait_tick(20, n);
        chk("presc_drop_period", n, 32'd6);

        i_run = 1'b0;
        repeat (3) next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

endmodule
